// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence detector.
// Holds FSM state encodings, overlap mode values and a length-width helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ARMED = 2'd1,
    S_MATCH = 2'd2
  } state_e;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Bits needed to hold a length in 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_history.sv
// History shift register and fill counter with masked pattern compare.
// Ports: clk, clr/fill_clr, shift+din, len/pattern in; match_next, full_next out.
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               fill_clr,
  input  logic               shift,
  input  logic               din,
  input  logic               clr_on_match,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  output logic               match_next,
  output logic               full_next
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      fill_inc;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
  end

  always_comb begin
    hist_sh    = {hist_q[MAX_LEN-2:0], din};
    fill_inc   = (fill_q >= len) ? len : fill_q + LW'(1);
    full_next  = shift && (fill_inc == len);
    match_next = shift && (fill_inc >= len)
              && (((hist_sh ^ pattern) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_sh;
      // Non-overlap: a match consumes its bits, so the
      // next match needs len fresh samples.
      fill_d = (match_next && clr_on_match) ? '0 : fill_inc;
    end else if (fill_clr) begin
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    hist_q <= hist_d;
    fill_q <= fill_d;
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Moore serial sequence detector with match counter.
// Ports: Clock, Reset_n, Din/Din_valid, Cfg_* load; Y, Match_count, Cfg_err.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 COUNT_W     = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1101,
  parameter int                 DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        Din,
  input  logic                        Din_valid,
  input  logic                        Cfg_load,
  input  logic [MAX_LEN-1:0]          Cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]   Cfg_len,
  input  logic                        Cfg_overlap,
  output logic                        Y,
  output logic [COUNT_W-1:0]          Match_count,
  output logic                        Cfg_err
);

  localparam int LW = len_w(MAX_LEN);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               y_q, y_d;
  logic               err_q, err_d;

  logic cfg_ok;
  logic good_load;
  logic sample;
  logic bad_state;
  logic match;
  logic full_next;
  logic hist_clr;

  assign hist_clr = !Reset_n || good_load;

  seq_det_history #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_hist (
    .clk          (Clock),
    .clr          (hist_clr),
    .fill_clr     (bad_state),
    .shift        (sample),
    .din          (Din),
    .clr_on_match (ovl_q == NON_OVERLAP),
    .pattern      (pat_q),
    .len          (len_q),
    .match_next   (match),
    .full_next    (full_next)
  );

  always_comb begin
    cfg_ok    = (Cfg_len != '0) && (Cfg_len <= LW'(MAX_LEN));
    good_load = Cfg_load && cfg_ok;
    sample    = Din_valid && !Cfg_load;
    bad_state = 1'b0;

    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (match)          state_d = S_MATCH;
        else if (full_next) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (match) state_d = S_MATCH;
      end
      S_MATCH: begin
        if (match)                state_d = S_MATCH;
        else if (ovl_q == OVERLAP) state_d = S_ARMED;
        else                      state_d = S_FILL;
      end
      default: begin
        state_d   = S_FILL;
        bad_state = 1'b1;
      end
    endcase

    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    cnt_d = cnt_q;
    if (good_load) begin
      pat_d   = Cfg_pattern;
      len_d   = Cfg_len;
      ovl_d   = Cfg_overlap;
      cnt_d   = '0;
      state_d = S_FILL;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end

    y_d   = (state_d == S_MATCH);
    err_d = Cfg_load && !cfg_ok;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_FILL;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign Y           = y_q;
  assign Match_count = cnt_q;
  assign Cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog.
// Second instance with COUNT_W=2 exercises counter saturation.
module tb_seq_detector_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_v;
  logic        cfg_load;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        cfg_ovl;
  logic        y, y2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic        err, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .Clock       (clk),
    .Reset_n     (rst_n),
    .Din         (din),
    .Din_valid   (din_v),
    .Cfg_load    (cfg_load),
    .Cfg_pattern (cfg_pat),
    .Cfg_len     (cfg_len),
    .Cfg_overlap (cfg_ovl),
    .Y           (y),
    .Match_count (cnt),
    .Cfg_err     (err)
  );

  seq_detector_prog #(.COUNT_W(2)) dut2 (
    .Clock       (clk),
    .Reset_n     (rst_n),
    .Din         (din),
    .Din_valid   (din_v),
    .Cfg_load    (cfg_load),
    .Cfg_pattern (cfg_pat),
    .Cfg_len     (cfg_len),
    .Cfg_overlap (cfg_ovl),
    .Y           (y2),
    .Match_count (cnt2),
    .Cfg_err     (err2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    din   = b;
    din_v = 1'b1;
    tick();
    din_v = 1'b0;
  endtask

  task automatic feed(input string tag, input logic [15:0] bits,
                      input int n, input logic [15:0] yexp);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in(bits[i]);
      chk($sformatf("%s_y%0d", tag, n - 1 - i), 32'(y), 32'(yexp[i]));
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l,
                      input logic o);
    cfg_pat  = p;
    cfg_len  = l;
    cfg_ovl  = o;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] pat3;

  initial begin
    din = 0; din_v = 0; cfg_load = 0;
    cfg_pat = 0; cfg_len = 0; cfg_ovl = 0;
    rst_n = 1'b1;
    #2;
    do_reset();
    chk("rst_y", 32'(y), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_err", 32'(err), 0);

    // default 1101 overlapping
    feed("t1", 16'b1101101, 7, 16'b0001001);
    chk("t1_cnt", 32'(cnt), 2);

    // non-overlap
    load(8'h0D, 4'd4, 1'b0);
    chk("t2_ld_cnt", 32'(cnt), 0);
    chk("t2_ld_y", 32'(y), 0);
    feed("t2a", 16'b1101101, 7, 16'b0001000);
    chk("t2a_cnt", 32'(cnt), 1);
    feed("t2b", 16'b1101, 4, 16'b0001);
    chk("t2b_cnt", 32'(cnt), 2);

    // len 8 with valid gaps
    pat3 = 8'hAA;
    load(pat3, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      bit_in(pat3[i]);
      chk($sformatf("t3_y%0d", 7 - i), 32'(y), 32'(i == 0));
      for (int g = 0; g < 3; g++) begin
        tick();
        chk($sformatf("t3_gap%0d_%0d", 7 - i, g), 32'(y), 0);
      end
    end
    chk("t3_cnt", 32'(cnt), 1);

    // rejected loads
    do_reset();
    feed("t4a", 16'b1101, 4, 16'b0001);
    chk("t4a_cnt", 32'(cnt), 1);
    load(8'hFF, 4'd0, 1'b0);
    chk("t4_err0", 32'(err), 1);
    chk("t4_cnt0", 32'(cnt), 1);
    tick();
    chk("t4_err0_off", 32'(err), 0);
    load(8'hFF, 4'd9, 1'b0);
    chk("t4_err9", 32'(err), 1);
    tick();
    chk("t4_err9_off", 32'(err), 0);
    feed("t4b", 16'b101, 3, 16'b001);
    chk("t4b_cnt", 32'(cnt), 2);

    // len 1, saturation on 2-bit counter
    load(8'h01, 4'd1, 1'b1);
    chk("t5_ld_cnt2", 32'(cnt2), 0);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1);
      chk($sformatf("t5_y%0d", i), 32'(y), 1);
      chk($sformatf("t5_cnt2_%0d", i), 32'(cnt2), (i + 1 > 3) ? 3 : i + 1);
    end
    chk("t5_cnt", 32'(cnt), 5);
    tick();
    chk("t5_y_end", 32'(y), 0);

    // reset mid-pattern
    do_reset();
    feed("t6a", 16'b110, 3, 16'b000);
    do_reset();
    feed("t6b", 16'b1, 1, 16'b0);
    chk("t6b_cnt", 32'(cnt), 0);

    // load wins over a coincident valid bit
    feed("t6c", 16'b110, 3, 16'b000);
    din   = 1'b1;
    din_v = 1'b1;
    load(8'h0D, 4'd4, 1'b1);
    din_v = 1'b0;
    feed("t6d", 16'b101, 3, 16'b000);
    chk("t6d_cnt", 32'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
